// File: rtl/multistart_sequencer.sv
// rtl/multistart_sequencer.sv - multi-start launcher for the Q24.8 gradient-descent core
//
// Purpose: launches the optimizer core NUM_STARTS times from x_start + k*x_step
// (saturating), does the level start/done handshake with it, and keeps the lowest
// y_min seen (earliest index on ties). A watchdog abandons the run if a start never
// completes.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   run                   one-cycle request, accepted in IDLE only
//   x_start, x_step       Q24.8 first point and spacing, latched on accept
//   opt_start_op          level start to the core
//   opt_initial_x         Q24.8 point presented to the core
//   opt_done_op           core completion level
//   opt_x_at_min          Q24.8 core result x
//   opt_y_min             Q47.8 core result y
//   busy, done            run in progress / run finished (held until next accept)
//   best_x, best_y        best result so far
//   best_idx              start index of the best result
//   sat_flag              some generated point saturated during this run
//   timeout_err           the watchdog fired during this run
module multistart_sequencer #(
  parameter int NUM_STARTS     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] x_start,
  input  logic [31:0] x_step,
  output logic        opt_start_op,
  output logic [31:0] opt_initial_x,
  input  logic        opt_done_op,
  input  logic [31:0] opt_x_at_min,
  input  logic [55:0] opt_y_min,
  output logic        busy,
  output logic        done,
  output logic [31:0] best_x,
  output logic [55:0] best_y,
  output logic [7:0]  best_idx,
  output logic        sat_flag,
  output logic        timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]      K_LAST  = 8'(NUM_STARTS - 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_DONE, S_CAPTURE, S_RELEASE, S_FINISH
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     x_step_q, x_step_d;
  logic [31:0]     init_x_q, init_x_d;
  logic [31:0]     best_x_q, best_x_d;
  logic [55:0]     best_y_q, best_y_d;
  logic [7:0]      k_q, k_d;
  logic [7:0]      best_idx_q, best_idx_d;
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            start_q, start_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sat_q, sat_d;
  logic            tmo_q, tmo_d;

  // Saturating next point: overflow when the two top bits of the 33-bit sum differ.
  logic [32:0] sum;
  logic        ovf;
  logic [31:0] next_x;
  logic        better;
  logic        wd_expired;

  assign sum        = {init_x_q[31], init_x_q} + {x_step_q[31], x_step_q};
  assign ovf        = sum[32] ^ sum[31];
  assign next_x     = ovf ? (sum[32] ? 32'h8000_0000 : 32'h7fff_ffff) : sum[31:0];
  // Strict less-than keeps the earlier index on ties; k==0 always seeds the run.
  assign better     = (k_q == 8'd0) || ($signed(opt_y_min) < $signed(best_y_q));
  // wdog_q counts completed WAIT_DONE cycles, so this is the TIMEOUT_CYCLES-th one.
  assign wd_expired = (wdog_q == WD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      x_step_q   <= '0;
      init_x_q   <= '0;
      best_x_q   <= '0;
      best_y_q   <= '0;
      k_q        <= '0;
      best_idx_q <= '0;
      wdog_q     <= '0;
      start_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_q      <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_step_q   <= x_step_d;
      init_x_q   <= init_x_d;
      best_x_q   <= best_x_d;
      best_y_q   <= best_y_d;
      k_q        <= k_d;
      best_idx_q <= best_idx_d;
      wdog_q     <= wdog_d;
      start_q    <= start_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_q      <= sat_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (run) state_d = S_LAUNCH;
      // Never raise start while the core still reports done from a previous launch.
      S_LAUNCH:    if (!opt_done_op) state_d = S_WAIT_DONE;
      // done is tested first so it wins over a simultaneous watchdog expiry.
      S_WAIT_DONE: if (opt_done_op) state_d = S_CAPTURE;
                   else if (wd_expired) state_d = S_FINISH;
      S_CAPTURE:   state_d = S_RELEASE;
      S_RELEASE:   if (!opt_done_op) state_d = (k_q == K_LAST) ? S_FINISH : S_LAUNCH;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    x_step_d   = x_step_q;
    init_x_d   = init_x_q;
    best_x_d   = best_x_q;
    best_y_d   = best_y_q;
    k_d        = k_q;
    best_idx_d = best_idx_q;
    wdog_d     = wdog_q;
    start_d    = start_q;
    busy_d     = busy_q;
    done_d     = done_q;
    sat_d      = sat_q;
    tmo_d      = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          x_step_d = x_step;
          init_x_d = x_start;
          k_d      = 8'd0;
          done_d   = 1'b0;
          sat_d    = 1'b0;
          tmo_d    = 1'b0;
          busy_d   = 1'b1;
        end
      end
      S_LAUNCH: begin
        if (!opt_done_op) begin
          start_d = 1'b1;
          wdog_d  = '0;
        end
      end
      S_WAIT_DONE: begin
        if (!opt_done_op) begin
          if (wd_expired) begin
            tmo_d   = 1'b1;
            start_d = 1'b0;
          end else begin
            wdog_d = wdog_q + WD_W'(1);
          end
        end
      end
      S_CAPTURE: begin
        if (better) begin
          best_y_d   = opt_y_min;
          best_x_d   = opt_x_at_min;
          best_idx_d = k_q;
        end
        start_d = 1'b0;
      end
      S_RELEASE: begin
        if (!opt_done_op) begin
          k_d = k_q + 8'd1;
          if (k_q != K_LAST) begin
            init_x_d = next_x;
            sat_d    = sat_q | ovf;
          end
        end
      end
      S_FINISH: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign opt_start_op  = start_q;
  assign opt_initial_x = init_x_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign best_x        = best_x_q;
  assign best_y        = best_y_q;
  assign best_idx      = best_idx_q;
  assign sat_flag      = sat_q;
  assign timeout_err   = tmo_q;

endmodule

// File: tb/tb_multistart_sequencer.sv
// tb/tb_multistart_sequencer.sv - self-checking bench for multistart_sequencer
module tb_multistart_sequencer;

  localparam int NS     = 8;
  localparam int TO     = 64;
  localparam int CORE_N = 16;
  localparam int NOM    = 2 + NS * (CORE_N + 7);
  localparam int BUDGET = 5000;

  logic        clk, rst_n, run;
  logic [31:0] x_start, x_step;
  logic        opt_start_op;
  logic [31:0] opt_initial_x;
  logic        opt_done_op;
  logic [31:0] opt_x_at_min;
  logic [55:0] opt_y_min;
  logic        busy, done;
  logic [31:0] best_x;
  logic [55:0] best_y;
  logic [7:0]  best_idx;
  logic        sat_flag, timeout_err;

  multistart_sequencer #(.NUM_STARTS(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .x_start(x_start), .x_step(x_step),
    .opt_start_op(opt_start_op), .opt_initial_x(opt_initial_x),
    .opt_done_op(opt_done_op), .opt_x_at_min(opt_x_at_min), .opt_y_min(opt_y_min),
    .busy(busy), .done(done), .best_x(best_x), .best_y(best_y), .best_idx(best_idx),
    .sat_flag(sat_flag), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Core model: done rises N+3 cycles after start rises (counting the start cycle),
  // and falls 2+hold cycles after start drops. Written only by the process below.
  int          core_k = 0, cnt = 0, rcnt = 0, viol = 0, unstable = 0;
  bit          started = 0;
  logic [31:0] launched[$];
  // Knobs written only by the tests.
  int          hang_k = -1, hold = 0, kbase = 0, lb = 0;
  logic [31:0] res_x[NS];
  logic [55:0] res_y[NS];

  always @(negedge clk) begin
    int idx;
    if (!rst_n) begin
      opt_done_op = 1'b0; opt_x_at_min = '0; opt_y_min = '0;
      started = 0; cnt = 0; rcnt = 0;
    end else if (opt_start_op) begin
      if (!started) begin
        started = 1; cnt = 0;
        if (opt_done_op) viol++;
        launched.push_back(opt_initial_x);
      end else if (opt_initial_x !== launched[$]) unstable++;
      if (!opt_done_op) begin
        cnt++;
        idx = core_k - kbase;
        if (cnt == CORE_N + 3 && idx >= 0 && idx < NS && idx != hang_k) begin
          opt_done_op = 1'b1; opt_x_at_min = res_x[idx]; opt_y_min = res_y[idx];
        end
      end
    end else begin
      if (started) begin started = 0; core_k++; rcnt = 0; end
      if (opt_done_op) begin
        rcnt++;
        if (rcnt >= 2 + hold) opt_done_op = 1'b0;
      end
    end
  end

  // Reference model: points by saturating arithmetic, best by a plain minimum search.
  logic [31:0] exp_pts[$];
  bit          exp_sat;
  logic [31:0] exp_bx;
  logic [55:0] exp_by;
  logic [7:0]  exp_bi;

  task automatic model_run(input logic [31:0] xs, input logic [31:0] st, input int gen, input int comp);
    longint p, hi, lo;
    hi = 64'sd2147483647; lo = -64'sd2147483648;
    exp_pts.delete(); exp_sat = 0;
    p = longint'($signed(xs));
    for (int k = 0; k < gen; k++) begin
      if (k > 0) begin
        p = p + longint'($signed(st));
        if (p > hi) begin p = hi; exp_sat = 1; end
        else if (p < lo) begin p = lo; exp_sat = 1; end
      end
      exp_pts.push_back(32'(p));
    end
    for (int k = 0; k < comp; k++)
      if (k == 0 || longint'($signed(res_y[k])) < longint'($signed(exp_by))) begin
        exp_by = res_y[k]; exp_bx = res_x[k]; exp_bi = 8'(k);
      end
  endtask

  task automatic model_reset();
    exp_bx = '0; exp_by = '0; exp_bi = '0;
  endtask

  task automatic start_run(input logic [31:0] xs, input logic [31:0] st);
    kbase = core_k; lb = launched.size();
    @(negedge clk); x_start = xs; x_step = st; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    x_start = $urandom; x_step = $urandom;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
    n_cmp++;
    if (done !== 1'b1) begin n_fail++; $display("FAIL wait_done: done=%b after %0d cycles, required 1", done, cyc); end
  endtask

  task automatic apply_reset();
    @(posedge clk); #2; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rand_results(input int ties);
    for (int k = 0; k < NS; k++) begin
      res_x[k] = $urandom;
      if (ties != 0) res_y[k] = 56'(longint'(int'($urandom_range(0, 3)) - 1) * 256);
      else res_y[k] = 56'({$urandom, $urandom});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; run = 1'b0; x_start = '0; x_step = '0;
    model_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({opt_start_op, busy, done, sat_flag, timeout_err} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: start/busy/done/sat/tmo=%b required 00000", {opt_start_op, busy, done, sat_flag, timeout_err});
    end
    n_cmp++;
    if ({best_x, best_y, best_idx, opt_initial_x} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: %h required 0", {best_x, best_y, best_idx, opt_initial_x});
    end
    @(posedge clk); #2; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({opt_start_op, busy, done} !== 3'b0) begin
      n_fail++; $display("FAIL idle_after_reset: start/busy/done=%b required 000", {opt_start_op, busy, done});
    end
  endtask

  task automatic test_real_core();
    int cyc, v0, u0;
    for (int k = 0; k < NS; k++) begin res_x[k] = 32'h400; res_y[k] = '0; end
    v0 = viol; u0 = unstable;
    start_run(32'h0, 32'h100);
    wait_done(cyc);
    model_run(32'h0, 32'h100, NS, NS);
    n_cmp++;
    if (cyc != NOM) begin n_fail++; $display("FAIL real_cycles: %0d required %0d", cyc, NOM); end
    n_cmp++;
    if ({best_idx, best_x, best_y, done} !== {8'd0, 32'h400, 56'd0, 1'b1}) begin
      n_fail++; $display("FAIL real_best: idx=%0d x=%h y=%h done=%b required 0/00000400/0/1", best_idx, best_x, best_y, done);
    end
    for (int i = 0; i < NS; i++) begin
      n_cmp++;
      if (lb + i >= launched.size() || launched[lb + i] !== 32'(i * 256)) begin
        n_fail++; $display("FAIL real_point[%0d]: launched %0d points, required x=%h", i, launched.size() - lb, 32'(i * 256));
      end
    end
    n_cmp++;
    if (viol != v0 || unstable != u0) begin
      n_fail++; $display("FAIL real_handshake: violations=%0d unstable=%0d required 0/0", viol - v0, unstable - u0);
    end
  endtask

  task automatic check_full(input string name, input int cyc, input int exp_cyc, input bit exp_tmo);
    // Stimulus-side bookkeeping only; each scenario task still owns its own comparisons below.
  endtask

  task automatic test_scripted();
    int cyc;
    int ys[NS] = '{50, 30, 30, 10, 40, 10, 60, 70};
    for (int k = 0; k < NS; k++) begin res_x[k] = $urandom; res_y[k] = 56'(ys[k] * 256); end
    start_run(32'hFFFF_F000, 32'h0000_0080);
    wait_done(cyc);
    model_run(32'hFFFF_F000, 32'h0000_0080, NS, NS);
    n_cmp++;
    if (cyc != NOM) begin n_fail++; $display("FAIL scripted_cycles: %0d required %0d", cyc, NOM); end
    n_cmp++;
    if ({best_idx, best_x, best_y} !== {8'd3, res_x[3], 56'(10 * 256)}) begin
      n_fail++; $display("FAIL scripted_best: idx=%0d x=%h y=%h required 3/%h/%h", best_idx, best_x, best_y, res_x[3], 56'(10 * 256));
    end
    n_cmp++;
    if ({sat_flag, timeout_err, done, busy} !== 4'b0010) begin
      n_fail++; $display("FAIL scripted_flags: sat/tmo/done/busy=%b required 0010", {sat_flag, timeout_err, done, busy});
    end
  endtask

  task automatic test_saturation();
    int cyc;
    rand_results(0);
    start_run(32'h7FFF_FE00, 32'h0000_0100);
    wait_done(cyc);
    model_run(32'h7FFF_FE00, 32'h0000_0100, NS, NS);
    n_cmp++;
    if ({best_idx, best_x, best_y, sat_flag, timeout_err, done} !== {exp_bi, exp_bx, exp_by, exp_sat, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL sat_result: idx=%0d x=%h y=%h sat=%b tmo=%b done=%b required %0d/%h/%h/%b/0/1", best_idx, best_x, best_y, sat_flag, timeout_err, done, exp_bi, exp_bx, exp_by, exp_sat);
    end
    for (int i = 0; i < NS; i++) begin
      n_cmp++;
      if (lb + i >= launched.size() || launched[lb + i] !== exp_pts[i]) begin
        n_fail++; $display("FAIL sat_point[%0d]: launched %0d points, required x=%h", i, launched.size() - lb, exp_pts[i]);
      end
    end
    n_cmp++;
    if (cyc != NOM) begin n_fail++; $display("FAIL sat_cycles: %0d required %0d", cyc, NOM); end
  endtask

  task automatic test_timeout();
    int cyc, exp_cyc;
    rand_results(0);
    hang_k = 2;
    start_run(32'h0000_1000, 32'hFFFF_FF00);
    wait_done(cyc);
    hang_k = -1;
    model_run(32'h0000_1000, 32'hFFFF_FF00, 3, 2);
    exp_cyc = 3 + 2 * (CORE_N + 7) + TO;
    n_cmp++;
    if (cyc != exp_cyc) begin n_fail++; $display("FAIL timeout_cycles: %0d required %0d", cyc, exp_cyc); end
    n_cmp++;
    if ({timeout_err, opt_start_op, done, busy} !== 4'b1010) begin
      n_fail++; $display("FAIL timeout_flags: tmo/start/done/busy=%b required 1010", {timeout_err, opt_start_op, done, busy});
    end
    n_cmp++;
    if ({best_idx, best_x, best_y} !== {exp_bi, exp_bx, exp_by}) begin
      n_fail++; $display("FAIL timeout_best: idx=%0d x=%h y=%h required %0d/%h/%h", best_idx, best_x, best_y, exp_bi, exp_bx, exp_by);
    end
    n_cmp++;
    if (launched.size() - lb != 3) begin n_fail++; $display("FAIL timeout_launches: %0d required 3", launched.size() - lb); end
  endtask

  task automatic test_timeout_first();
    int cyc;
    apply_reset();
    rand_results(0);
    hang_k = 0;
    start_run($urandom, $urandom);
    wait_done(cyc);
    hang_k = -1;
    n_cmp++;
    if (cyc != 3 + TO) begin n_fail++; $display("FAIL timeout0_cycles: %0d required %0d", cyc, 3 + TO); end
    n_cmp++;
    if ({best_idx, best_x, best_y, timeout_err} !== {8'd0, 32'd0, 56'd0, 1'b1}) begin
      n_fail++; $display("FAIL timeout0_best: idx=%0d x=%h y=%h tmo=%b required 0/0/0/1", best_idx, best_x, best_y, timeout_err);
    end
  endtask

  task automatic test_run_ignored_reset();
    int cyc, t;
    logic [31:0] xa, sa;
    rand_results(0);
    xa = 32'($urandom_range(0, 32'h0010_0000)); sa = 32'($urandom_range(1, 32'h1000));
    start_run(xa, sa);
    t = 0;
    while (core_k - kbase < 1 && t < BUDGET) begin @(posedge clk); #1; t++; end
    @(negedge clk); x_start = 32'h5555_0000; x_step = 32'h0000_7777; run = 1'b1;
    @(negedge clk); run = 1'b0;
    t = 0;
    while (!(core_k - kbase == 4 && opt_start_op && !opt_done_op) && t < BUDGET) begin @(posedge clk); #1; t++; end
    n_cmp++;
    if (t >= BUDGET) begin n_fail++; $display("FAIL midrun_reach_k4: waited %0d cycles, required < %0d", t, BUDGET); end
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({opt_start_op, busy, done} !== 3'b000) begin
      n_fail++; $display("FAIL async_reset_ctrl: start/busy/done=%b required 000", {opt_start_op, busy, done});
    end
    n_cmp++;
    if ({best_x, best_y, best_idx} !== 96'd0) begin
      n_fail++; $display("FAIL async_reset_best: %h required 0", {best_x, best_y, best_idx});
    end
    model_run(xa, sa, 5, 0);
    n_cmp++;
    if (launched.size() - lb != 5) begin n_fail++; $display("FAIL midrun_launches: %0d required 5", launched.size() - lb); end
    for (int i = 0; i < 5; i++) begin
      n_cmp++;
      if (lb + i >= launched.size() || launched[lb + i] !== exp_pts[i]) begin
        n_fail++; $display("FAIL midrun_point[%0d]: launched %0d points, required x=%h", i, launched.size() - lb, exp_pts[i]);
      end
    end
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    model_reset();
    rand_results(0);
    start_run(32'hFFFF_0000, 32'h0000_0200);
    wait_done(cyc);
    model_run(32'hFFFF_0000, 32'h0000_0200, NS, NS);
    n_cmp++;
    if (cyc != NOM || launched.size() - lb != NS || launched[lb] !== 32'hFFFF_0000) begin
      n_fail++; $display("FAIL fresh_run: cycles=%0d launches=%0d required %0d/%0d from ffff0000", cyc, launched.size() - lb, NOM, NS);
    end
    n_cmp++;
    if ({best_idx, best_x, best_y} !== {exp_bi, exp_bx, exp_by}) begin
      n_fail++; $display("FAIL fresh_best: idx=%0d x=%h y=%h required %0d/%h/%h", best_idx, best_x, best_y, exp_bi, exp_bx, exp_by);
    end
  endtask

  task automatic test_handshake_hold();
    int cyc, v0, exp_cyc;
    rand_results(1);
    hold = 5; v0 = viol;
    start_run($urandom, 32'($urandom_range(0, 32'h0100_0000)));
    wait_done(cyc);
    hold = 0;
    exp_cyc = 2 + NS * (CORE_N + 12);
    n_cmp++;
    if (cyc != exp_cyc) begin n_fail++; $display("FAIL hold_cycles: %0d required %0d", cyc, exp_cyc); end
    n_cmp++;
    if (viol != v0) begin n_fail++; $display("FAIL hold_start_while_done: %0d events required 0", viol - v0); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0] xs;
    rand_results(1);
    xs = $urandom;
    kbase = core_k; lb = launched.size();
    @(negedge clk); x_start = xs; x_step = 32'h0000_0040; run = 1'b1;
    @(posedge clk); #1; cyc = 1; x_start = $urandom;
    while (done !== 1'b1 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
    run = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    model_run(xs, 32'h0000_0040, NS, NS);
    n_cmp++;
    if (cyc != NOM || {busy, done} !== 2'b01 || launched.size() - lb != NS) begin
      n_fail++; $display("FAIL held_run: cycles=%0d busy/done=%b launches=%0d required %0d/01/%0d", cyc, {busy, done}, launched.size() - lb, NOM, NS);
    end
    n_cmp++;
    if ({best_idx, best_x, best_y} !== {exp_bi, exp_bx, exp_by}) begin
      n_fail++; $display("FAIL held_best: idx=%0d x=%h y=%h required %0d/%h/%h", best_idx, best_x, best_y, exp_bi, exp_bx, exp_by);
    end
    rand_results(1);
    start_run(32'h8000_0100, 32'hFFFF_FF80);
    wait_done(cyc);
    model_run(32'h8000_0100, 32'hFFFF_FF80, NS, NS);
    n_cmp++;
    if ({best_idx, best_x, best_y, sat_flag, cyc} !== {exp_bi, exp_bx, exp_by, exp_sat, NOM}) begin
      n_fail++; $display("FAIL b2b_result: idx=%0d x=%h y=%h sat=%b cyc=%0d required %0d/%h/%h/%b/%0d", best_idx, best_x, best_y, sat_flag, cyc, exp_bi, exp_bx, exp_by, exp_sat, NOM);
    end
  endtask

  task automatic test_random();
    int cyc;
    logic [31:0] xs, st;
    for (int r = 0; r < 4; r++) begin
      rand_results(r % 2);
      xs = (r < 2) ? $urandom : (32'h7FFF_0000 ^ 32'($urandom_range(0, 32'h0001_FFFF)));
      st = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 32'h0000_8000));
      start_run(xs, st);
      wait_done(cyc);
      model_run(xs, st, NS, NS);
      n_cmp++;
      if ({best_idx, best_x, best_y, sat_flag, timeout_err, cyc} !== {exp_bi, exp_bx, exp_by, exp_sat, 1'b0, NOM}) begin
        n_fail++; $display("FAIL random%0d_result: idx=%0d x=%h y=%h sat=%b tmo=%b cyc=%0d required %0d/%h/%h/%b/0/%0d", r, best_idx, best_x, best_y, sat_flag, timeout_err, cyc, exp_bi, exp_bx, exp_by, exp_sat, NOM);
      end
      for (int i = 0; i < NS; i++) begin
        n_cmp++;
        if (lb + i >= launched.size() || launched[lb + i] !== exp_pts[i]) begin
          n_fail++; $display("FAIL random%0d_point[%0d]: launched %0d points, required x=%h", r, i, launched.size() - lb, exp_pts[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_real_core();
    test_scripted();
    test_saturation();
    test_timeout();
    test_handshake_hold();
    test_back_to_back();
    test_random();
    test_timeout_first();
    test_run_ignored_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation still running at 2000000, required to have finished");
    $fatal(1);
  end

endmodule
